arm_decode_stage: RTL and testbench
===================================

Name: arm_decode_stage

Overview:
- Instruction-decode stage of the 5-stage ARM-subset pipeline. Sits between the IF/ID pipeline register and the ID/EX pipeline register.
- Decodes a 32-bit ARM-format instruction and reads two operands from an internal 16x32 register file.
- Evaluates the condition field against the status register, then emits control signals, operands and register addresses for hazard detection.
- Register-file writes come from the write-back stage.

Parameters:
- None. Data width is fixed at 32 bits; register file is 16 entries.

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- Instruction  in  32  instruction from IF/ID register
- Result_WB  in  32  write-back data
- writeBackEn  in  1  register-file write enable from WB
- Dest_wb  in  4  register-file write address from WB
- hazard  in  1  hazard unit stall request; forces bubble control
- SR  in  4  status flags {N,Z,C,V} = SR[3:0]
- WB_EN, MEM_R_EN, MEM_W_EN, B, S  out  1 each  control outputs
- EXE_CMD  out  4  ALU command
- Val_Rn, Val_Rm  out  32  operand values
- imm  out  1  Instruction[25]
- Shift_operand  out  12  Instruction[11:0]
- Signed_imm_24  out  24  Instruction[23:0]
- Dest  out  4  Instruction[15:12]
- src1, src2  out  4  read addresses, for hazard detection
- Two_src  out  1  instruction reads a second register

Behaviour:
Instruction field layout:
- cond = [31:28], mode = [27:26], I = [25], opcode = [24:21], S = [20], Rn = [19:16], Rd = [15:12].

Outputs and read path:
- All outputs are combinational. The only state is the register file.
- src1 = Rn.
- src2 = Rd when MEM_W_EN (pre-gating store decode), otherwise Instruction[3:0].
- Two_src = ~I | store.
- Val_Rn = RF[src1]; Val_Rm = RF[src2].

Register file:
- Written on the rising clk edge when writeBackEn=1: RF[Dest_wb] <= Result_WB.
- Synchronous reset sets RF[i] = i for i = 0..15. Reset has priority over a write in the same cycle.

Decode, mode 00 (data processing). WB_EN=1 except for CMP/TST. S output = Instruction[20].
- MOV 1101 -> EXE_CMD 0001
- MVN 1111 -> 1001
- ADD 0100 -> 0010
- ADC 0101 -> 0011
- SUB 0010 -> 0100
- SBC 0110 -> 0101
- AND 0000 -> 0110
- ORR 1100 -> 0111
- EOR 0001 -> 1000
- CMP 1010 -> 0100, WB_EN=0
- TST 1000 -> 0110, WB_EN=0
- Any other opcode: all controls 0.

Decode, other modes:
- Mode 01, S=1: LDR -> EXE_CMD 0010, MEM_R_EN=1, WB_EN=1.
- Mode 01, S=0: STR -> EXE_CMD 0010, MEM_W_EN=1. S output is 0 for memory ops.
- Mode 10: B=1, all else 0.
- Mode 11: all controls 0.

Condition codes:
- EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V
- HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V)
- AL 1110 -> 1; 1111 -> 0

Bubble gating:
- If hazard=1 or the condition fails: WB_EN, MEM_R_EN, MEM_W_EN, B, S and EXE_CMD are forced to 0.
- Operand, address and immediate outputs are unaffected by gating.

Reset:
- During reset the outputs still follow the combinational decode; only RF contents are reset.
- Reset asserted mid-operation discards any pending write in that cycle.

Optional Feature:
- Macro RF_BYPASS_EN.
- When defined: a read whose address equals Dest_wb while writeBackEn=1 returns Result_WB in the same cycle (write-through). This lets WB and ID of dependent instructions overlap without an extra stall.
- When undefined: reads return the stored value; the new value is visible from the cycle after the write edge.

Test Plan:
- Reset: assert rst for one edge, then decode 0xE0821003 (ADD R1,R2,R3) -> Val_Rn=2, Val_Rm=3, EXE_CMD=0010, WB_EN=1, Dest=1, Two_src=1.
- Immediate MOV 0xE3A0100A -> imm=1, EXE_CMD=0001, Shift_operand=0x00A, Two_src=0, WB_EN=1.
- Store 0xE5812000 (STR R2,[R1]) -> MEM_W_EN=1, WB_EN=0, src2=2, Two_src=1, EXE_CMD=0010. LDR 0xE5912000 -> MEM_R_EN=1, WB_EN=1.
- Condition/hazard gating:
  - 0x00821003 (ADDEQ) with SR=0000 -> all controls 0; with SR=0100 -> WB_EN=1.
  - Any AL instruction with hazard=1 -> all controls 0, but src1/src2 still driven.
- Write-back: writeBackEn=1, Dest_wb=5, Result_WB=0xDEADBEEF for one edge, then read R5 -> 0xDEADBEEF.
  - Same-cycle read returns 0xDEADBEEF only with RF_BYPASS_EN defined.
  - rst together with a write leaves R5=5.
- Branch 0xEAFFFFFE -> B=1, Signed_imm_24=0xFFFFFE, WB_EN=0. CMP 0xE1510002 -> EXE_CMD=0100, WB_EN=0, S=1.

Source files
------------

// File: rtl/arm_decode_stage.sv
// ID stage: field decode, condition check, bubble gating and 16x32 register file.
// Optional RF_BYPASS_EN: a write-back to the register being read shows up in the same cycle.
module arm_decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instruction,
   input  logic [31:0] Result_WB,
   input  logic        writeBackEn,
   input  logic [3:0]  Dest_wb,
   input  logic        hazard,
   input  logic [3:0]  SR,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic        B,
   output logic        S,
   output logic [3:0]  EXE_CMD,
   output logic [31:0] Val_Rn,
   output logic [31:0] Val_Rm,
   output logic        imm,
   output logic [11:0] Shift_operand,
   output logic [23:0] Signed_imm_24,
   output logic [3:0]  Dest,
   output logic [3:0]  src1,
   output logic [3:0]  src2,
   output logic        Two_src
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;

   logic [3:0]  cond;
   logic [1:0]  mode;
   logic        i_bit;
   logic [3:0]  opcode;
   logic        s_bit;
   logic [3:0]  rn;
   logic [3:0]  rd;

   logic        wb_raw;
   logic        mr_raw;
   logic        mw_raw;
   logic        br_raw;
   logic        s_raw;
   logic [3:0]  cmd_raw;
   logic        cond_ok;
   logic        bubble;

   logic        flag_n;
   logic        flag_z;
   logic        flag_c;
   logic        flag_v;

   logic [31:0] rf [16];

   assign cond   = Instruction[31:28];
   assign mode   = Instruction[27:26];
   assign i_bit  = Instruction[25];
   assign opcode = Instruction[24:21];
   assign s_bit  = Instruction[20];
   assign rn     = Instruction[19:16];
   assign rd     = Instruction[15:12];

   assign flag_n = SR[3];
   assign flag_z = SR[2];
   assign flag_c = SR[1];
   assign flag_v = SR[0];

   // Raw control decode from mode/opcode, before condition and hazard gating.
   always_comb begin
      wb_raw  = 1'b0;
      mr_raw  = 1'b0;
      mw_raw  = 1'b0;
      br_raw  = 1'b0;
      s_raw   = 1'b0;
      cmd_raw = 4'b0000;
      unique case (mode)
         2'b00: begin
            s_raw  = s_bit;
            wb_raw = 1'b1;
            unique case (opcode)
               OP_MOV:  cmd_raw = CMD_MOV;
               OP_MVN:  cmd_raw = CMD_MVN;
               OP_ADD:  cmd_raw = CMD_ADD;
               OP_ADC:  cmd_raw = CMD_ADC;
               OP_SUB:  cmd_raw = CMD_SUB;
               OP_SBC:  cmd_raw = CMD_SBC;
               OP_AND:  cmd_raw = CMD_AND;
               OP_ORR:  cmd_raw = CMD_ORR;
               OP_EOR:  cmd_raw = CMD_EOR;
               OP_CMP: begin
                  cmd_raw = CMD_SUB;
                  wb_raw  = 1'b0;
               end
               OP_TST: begin
                  cmd_raw = CMD_AND;
                  wb_raw  = 1'b0;
               end
               default: begin
                  cmd_raw = 4'b0000;
                  wb_raw  = 1'b0;
                  s_raw   = 1'b0;
               end
            endcase
         end
         2'b01: begin
            cmd_raw = CMD_ADD;
            if (s_bit) begin
               mr_raw = 1'b1;
               wb_raw = 1'b1;
            end else begin
               mw_raw = 1'b1;
            end
         end
         2'b10: br_raw = 1'b1;
         default: ;
      endcase
   end

   // Condition field evaluated against the {N,Z,C,V} flags.
   always_comb begin
      cond_ok = 1'b0;
      unique case (cond)
         4'b0000: cond_ok = flag_z;
         4'b0001: cond_ok = ~flag_z;
         4'b0010: cond_ok = flag_c;
         4'b0011: cond_ok = ~flag_c;
         4'b0100: cond_ok = flag_n;
         4'b0101: cond_ok = ~flag_n;
         4'b0110: cond_ok = flag_v;
         4'b0111: cond_ok = ~flag_v;
         4'b1000: cond_ok = flag_c & ~flag_z;
         4'b1001: cond_ok = ~flag_c | flag_z;
         4'b1010: cond_ok = (flag_n == flag_v);
         4'b1011: cond_ok = (flag_n != flag_v);
         4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ok = flag_z | (flag_n != flag_v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   assign bubble = hazard | ~cond_ok;

   // Stalled or condition-failed instructions become bubbles.
   always_comb begin
      WB_EN    = wb_raw;
      MEM_R_EN = mr_raw;
      MEM_W_EN = mw_raw;
      B        = br_raw;
      S        = s_raw;
      EXE_CMD  = cmd_raw;
      if (bubble) begin
         WB_EN    = 1'b0;
         MEM_R_EN = 1'b0;
         MEM_W_EN = 1'b0;
         B        = 1'b0;
         S        = 1'b0;
         EXE_CMD  = 4'b0000;
      end
   end

   // A store reads its data register from Rd, so src2 uses the ungated store decode.
   assign src1          = rn;
   assign src2          = mw_raw ? rd : Instruction[3:0];
   assign Two_src       = ~i_bit | mw_raw;
   assign imm           = i_bit;
   assign Shift_operand = Instruction[11:0];
   assign Signed_imm_24 = Instruction[23:0];
   assign Dest          = rd;

   // Register file: reset loads RF[i] = i and overrides a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            rf[i] <= 32'(i);
         end
      end else if (writeBackEn) begin
         rf[Dest_wb] <= Result_WB;
      end
   end

`ifdef RF_BYPASS_EN
   assign Val_Rn = (writeBackEn && (Dest_wb == src1)) ? Result_WB : rf[src1];
   assign Val_Rm = (writeBackEn && (Dest_wb == src2)) ? Result_WB : rf[src2];
`else
   assign Val_Rn = rf[src1];
   assign Val_Rm = rf[src2];
`endif

endmodule

// File: tb/tb_arm_decode_stage.sv
// Scoreboard bench for arm_decode_stage: expected outputs are queued at drive time
// and compared against the DUT mid-cycle.
module tb_arm_decode_stage;

   logic        clk;
   logic        rst;
   logic [31:0] Instruction;
   logic [31:0] Result_WB;
   logic        writeBackEn;
   logic [3:0]  Dest_wb;
   logic        hazard;
   logic [3:0]  SR;
   logic        WB_EN;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic        B;
   logic        S;
   logic [3:0]  EXE_CMD;
   logic [31:0] Val_Rn;
   logic [31:0] Val_Rm;
   logic        imm;
   logic [11:0] Shift_operand;
   logic [23:0] Signed_imm_24;
   logic [3:0]  Dest;
   logic [3:0]  src1;
   logic [3:0]  src2;
   logic        Two_src;

   typedef struct {
      logic [4:0]  ctl;
      logic [3:0]  exe;
      logic [31:0] rn;
      logic [31:0] rm;
      logic        imm;
      logic [11:0] sh;
      logic [23:0] si;
      logic [3:0]  dest;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        two;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   arm_decode_stage dut (
      .clk(clk), .rst(rst), .Instruction(Instruction),
      .Result_WB(Result_WB), .writeBackEn(writeBackEn),
      .Dest_wb(Dest_wb), .hazard(hazard), .SR(SR),
      .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .B(B), .S(S), .EXE_CMD(EXE_CMD),
      .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
      .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
      .Dest(Dest), .src1(src1), .src2(src2), .Two_src(Two_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one instruction and queue what the outputs must be.
   task automatic drive(input logic [31:0] ins, input logic [3:0] sr_v,
                        input logic hz, input logic [4:0] ctl,
                        input logic [3:0] exe, input logic [31:0] rn_v,
                        input logic [31:0] rm_v, input logic [3:0] s2,
                        input logic two);
      exp_t e;
      Instruction = ins;
      SR          = sr_v;
      hazard      = hz;
      e.ctl  = ctl;
      e.exe  = exe;
      e.rn   = rn_v;
      e.rm   = rm_v;
      e.imm  = ins[25];
      e.sh   = ins[11:0];
      e.si   = ins[23:0];
      e.dest = ins[15:12];
      e.s1   = ins[19:16];
      e.s2   = s2;
      e.two  = two;
      sb.push_back(e);
   endtask

   // Pop the oldest expectation and compare after outputs settle.
   task automatic observe(input string tag);
      exp_t e;
      #2;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_ctl"}, 32'({WB_EN, MEM_R_EN, MEM_W_EN, B, S}),
               32'(e.ctl));
         check({tag, "_exe"}, 32'(EXE_CMD), 32'(e.exe));
         check({tag, "_rn"}, Val_Rn, e.rn);
         check({tag, "_rm"}, Val_Rm, e.rm);
         check({tag, "_imm"}, 32'(imm), 32'(e.imm));
         check({tag, "_sh"}, 32'(Shift_operand), 32'(e.sh));
         check({tag, "_si"}, 32'(Signed_imm_24), 32'(e.si));
         check({tag, "_dest"}, 32'(Dest), 32'(e.dest));
         check({tag, "_src1"}, 32'(src1), 32'(e.s1));
         check({tag, "_src2"}, 32'(src2), 32'(e.s2));
         check({tag, "_two"}, 32'(Two_src), 32'(e.two));
      end
   endtask

   function automatic logic cond_pass(input logic [3:0] c,
                                      input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cf;
         4'h3: return !cf;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cf && !z;
         4'h9: return !cf || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // {valid, writes back, alu command} for a data-processing opcode.
   function automatic logic [5:0] dp_ref(input logic [3:0] op);
      case (op)
         4'b1101: return {2'b11, 4'b0001};
         4'b1111: return {2'b11, 4'b1001};
         4'b0100: return {2'b11, 4'b0010};
         4'b0101: return {2'b11, 4'b0011};
         4'b0010: return {2'b11, 4'b0100};
         4'b0110: return {2'b11, 4'b0101};
         4'b0000: return {2'b11, 4'b0110};
         4'b1100: return {2'b11, 4'b0111};
         4'b0001: return {2'b11, 4'b1000};
         4'b1010: return {2'b10, 4'b0100};
         4'b1000: return {2'b10, 4'b0110};
         default: return 6'b0;
      endcase
   endfunction

   logic [31:0] rd5_same;

   initial begin
      rst         = 1'b1;
      Instruction = 32'h0;
      Result_WB   = 32'h0;
      writeBackEn = 1'b0;
      Dest_wb     = 4'd0;
      hazard      = 1'b0;
      SR          = 4'h0;
      @(negedge clk);
      rst = 1'b0;

      drive(32'hE0821003, 4'h0, 1'b0, 5'b10000, 4'b0010, 32'd2, 32'd3,
            4'd3, 1'b1);
      observe("add");
      @(negedge clk);
      drive(32'hE08FE00E, 4'h0, 1'b0, 5'b10000, 4'b0010, 32'd15, 32'd14,
            4'd14, 1'b1);
      observe("add_r15");
      @(negedge clk);
      drive(32'hE3A0100A, 4'h0, 1'b0, 5'b10000, 4'b0001, 32'd0, 32'd10,
            4'd10, 1'b0);
      observe("mov_imm");
      @(negedge clk);
      drive(32'hE5812000, 4'h0, 1'b0, 5'b00100, 4'b0010, 32'd1, 32'd2,
            4'd2, 1'b1);
      observe("str");
      @(negedge clk);
      drive(32'hE5912000, 4'h0, 1'b0, 5'b11000, 4'b0010, 32'd1, 32'd0,
            4'd0, 1'b1);
      observe("ldr");
      @(negedge clk);
      drive(32'h00821003, 4'h0, 1'b0, 5'b00000, 4'b0000, 32'd2, 32'd3,
            4'd3, 1'b1);
      observe("addeq_fail");
      @(negedge clk);
      drive(32'h00821003, 4'h4, 1'b0, 5'b10000, 4'b0010, 32'd2, 32'd3,
            4'd3, 1'b1);
      observe("addeq_pass");
      @(negedge clk);
      drive(32'hE0821003, 4'h0, 1'b1, 5'b00000, 4'b0000, 32'd2, 32'd3,
            4'd3, 1'b1);
      observe("hazard_add");
      @(negedge clk);
      drive(32'hE5812000, 4'h0, 1'b1, 5'b00000, 4'b0000, 32'd1, 32'd2,
            4'd2, 1'b1);
      observe("hazard_str");
      @(negedge clk);
      drive(32'hEAFFFFFE, 4'h0, 1'b0, 5'b00010, 4'b0000, 32'd15, 32'd14,
            4'd14, 1'b0);
      observe("branch");
      @(negedge clk);
      drive(32'hE1510002, 4'h0, 1'b0, 5'b00001, 4'b0100, 32'd1, 32'd2,
            4'd2, 1'b1);
      observe("cmp");
      @(negedge clk);
      drive(32'hEC000000, 4'h0, 1'b0, 5'b00000, 4'b0000, 32'd0, 32'd0,
            4'd0, 1'b1);
      observe("mode11");

      // Write-back of R5 and same-cycle read through Rn and Rm.
`ifdef RF_BYPASS_EN
      rd5_same = 32'hDEADBEEF;
`else
      rd5_same = 32'd5;
`endif
      @(negedge clk);
      writeBackEn = 1'b1;
      Dest_wb     = 4'd5;
      Result_WB   = 32'hDEADBEEF;
      drive(32'hE0850005, 4'h0, 1'b0, 5'b10000, 4'b0010, rd5_same,
            rd5_same, 4'd5, 1'b1);
      observe("wb_same");
      @(negedge clk);
      writeBackEn = 1'b0;
      drive(32'hE0850005, 4'h0, 1'b0, 5'b10000, 4'b0010, 32'hDEADBEEF,
            32'hDEADBEEF, 4'd5, 1'b1);
      observe("wb_after");

      // Reset beats a simultaneous write and restores R5.
      @(negedge clk);
      rst         = 1'b1;
      writeBackEn = 1'b1;
      Dest_wb     = 4'd5;
      Result_WB   = 32'h12345678;
      @(negedge clk);
      rst         = 1'b0;
      writeBackEn = 1'b0;
      drive(32'hE0850005, 4'h0, 1'b0, 5'b10000, 4'b0010, 32'd5, 32'd5,
            4'd5, 1'b1);
      observe("rst_vs_wb");

      // Every data-processing opcode with S=1.
      for (int op = 0; op < 16; op++) begin
         logic [5:0]  r;
         logic [31:0] ins;
         r   = dp_ref(4'(op));
         ins = {4'hE, 2'b00, 1'b0, 4'(op), 1'b1, 4'd2, 4'd1, 8'h00, 4'd3};
         @(negedge clk);
         drive(ins, 4'h0, 1'b0, r[5] ? {r[4], 3'b000, 1'b1} : 5'b0,
               r[3:0], 32'd2, 32'd3, 4'd3, 1'b1);
         observe($sformatf("op%0d", op));
      end

      // Every condition code against every flag combination.
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            logic        ok;
            logic [31:0] ins;
            ok  = cond_pass(4'(c), 4'(f));
            ins = {4'(c), 28'h0821003};
            @(negedge clk);
            drive(ins, 4'(f), 1'b0, ok ? 5'b10000 : 5'b0,
                  ok ? 4'b0010 : 4'b0, 32'd2, 32'd3, 4'd3, 1'b1);
            observe($sformatf("cond%0d_sr%0d", c, f));
         end
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
